// File: rtl/regfile_ctrl_pkg.sv
// Shared types and constants for the register-file write controller.
// Holds width defaults, the controller state encoding and requester IDs.
package regfile_ctrl_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 2;

  typedef enum logic {
    ARB   = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int REQ_A = 0;
  localparam int REQ_B = 1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: a lone requester always wins, ties go to the
// pointed-at port, and the pointer moves past whoever was granted.
module rr_arb2
  import regfile_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  // ptr_reg names the port that wins a tie (0 = A, 1 = B).
  logic ptr_reg;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_gnt
      assign gnt[gi] = en & req[gi] & (~req[1-gi] | (ptr_reg == 1'(gi)));
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_reg <= 1'(REQ_A);
    end else if (|gnt) begin
      ptr_reg <= gnt[REQ_A];
    end
  end

endmodule

// File: rtl/regfile_write_ctrl.sv
// Owns the single write port of the register file: round-robin arbitration of
// core (A) and debug (B) writes, a zeroing sequence, and a RAW hazard flag.
module regfile_write_ctrl
  import regfile_ctrl_pkg::*;
#(
  parameter int                DATA_W    = DEF_DATA_W,
  parameter int                ADDR_W    = DEF_ADDR_W,
  parameter int                NUM_REGS  = 4,
  parameter logic [DATA_W-1:0] CLR_VALUE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              raw_hazard,
  output logic              last_grant_b
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next, cnt_inc;
  logic              we_next, busy_next, done_next, lgb_next;
  logic [ADDR_W-1:0] waddr_next;
  logic [DATA_W-1:0] wdata_next;
  logic              arb_en;
  logic [1:0]        gnt;

  // Gating with reset keeps both readies low while reset is held.
  assign arb_en = reset & (state_reg == ARB) & ~clr_req;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   ({b_valid, a_valid}),
    .en    (arb_en),
    .gnt   (gnt)
  );

  assign a_ready    = gnt[REQ_A];
  assign b_ready    = gnt[REQ_B];
  assign cnt_inc    = cnt_reg + ADDR_W'(1);
  assign raw_hazard = rf_we & ((rf_waddr == rd_addr1) | (rf_waddr == rd_addr2));

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    we_next    = 1'b0;
    waddr_next = rf_waddr;
    wdata_next = rf_wdata;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    lgb_next   = last_grant_b;
    case (state_reg)
      ARB: begin
        if (clr_req) begin
          // First clear write goes out on the very next cycle.
          state_next = CLEAR;
          cnt_next   = '0;
          we_next    = 1'b1;
          waddr_next = '0;
          wdata_next = CLR_VALUE;
          busy_next  = 1'b1;
          done_next  = (LAST_ADDR == '0);
        end else if (a_valid & a_ready) begin
          we_next    = 1'b1;
          waddr_next = a_addr;
          wdata_next = a_data;
          lgb_next   = 1'b0;
        end else if (b_valid & b_ready) begin
          we_next    = 1'b1;
          waddr_next = b_addr;
          wdata_next = b_data;
          lgb_next   = 1'b1;
        end
      end
      CLEAR: begin
        if (cnt_reg == LAST_ADDR) begin
          state_next = ARB;
        end else begin
          cnt_next   = cnt_inc;
          we_next    = 1'b1;
          waddr_next = cnt_inc;
          wdata_next = CLR_VALUE;
          busy_next  = 1'b1;
          done_next  = (cnt_inc == LAST_ADDR);
        end
      end
      default: state_next = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ARB;
      cnt_reg      <= '0;
      rf_we        <= 1'b0;
      rf_waddr     <= '0;
      rf_wdata     <= '0;
      clr_busy     <= 1'b0;
      clr_done     <= 1'b0;
      last_grant_b <= 1'b0;
    end else begin
      state_reg    <= state_next;
      cnt_reg      <= cnt_next;
      rf_we        <= we_next;
      rf_waddr     <= waddr_next;
      rf_wdata     <= wdata_next;
      clr_busy     <= busy_next;
      clr_done     <= done_next;
      last_grant_b <= lgb_next;
    end
  end

endmodule

// File: tb/tb_regfile_write_ctrl.sv
// Directed bench for regfile_write_ctrl: arbitration, latency, clear sequence,
// reset during clear and the RAW hazard flag, against hand-computed values.
module tb_regfile_write_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       a_valid, b_valid, clr_req;
  logic [1:0] a_addr, b_addr, rd_addr1, rd_addr2;
  logic [7:0] a_data, b_data;
  logic       a_ready, b_ready, clr_busy, clr_done;
  logic       rf_we, raw_hazard, last_grant_b;
  logic [1:0] rf_waddr;
  logic [7:0] rf_wdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  regfile_write_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .a_valid      (a_valid),
    .a_addr       (a_addr),
    .a_data       (a_data),
    .a_ready      (a_ready),
    .b_valid      (b_valid),
    .b_addr       (b_addr),
    .b_data       (b_data),
    .b_ready      (b_ready),
    .clr_req      (clr_req),
    .clr_busy     (clr_busy),
    .clr_done     (clr_done),
    .rd_addr1     (rd_addr1),
    .rd_addr2     (rd_addr2),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .raw_hazard   (raw_hazard),
    .last_grant_b (last_grant_b)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset   = 1'b0;
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    clr_req = 1'b0; rd_addr1 = 2'd3; rd_addr2 = 2'd3;
    tick();
    tick();
    reset = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    a_valid = 1'b1; b_valid = 1'b1; clr_req = 1'b0;
    a_addr = 2'd1; b_addr = 2'd2; a_data = 8'hAA; b_data = 8'hBB;
    rd_addr1 = 2'd0; rd_addr2 = 2'd0;
    tick();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, clr_busy, clr_done, last_grant_b} !== 14'd0) begin
      errors++;
      $display("FAIL reset_outputs: we=%b waddr=%0d wdata=%h busy=%b done=%b lgb=%b required all 0",
               rf_we, rf_waddr, rf_wdata, clr_busy, clr_done, last_grant_b);
    end
    checks++;
    if ({a_ready, b_ready, raw_hazard} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ready: a_ready=%b b_ready=%b raw_hazard=%b required 000", a_ready, b_ready, raw_hazard);
    end
    $display("reset: checked idle outputs under reset");
  endtask

  task automatic test_single_write();
    apply_reset();
    a_valid = 1'b1; a_addr = 2'd2; a_data = 8'h5A;
    #1;
    checks++;
    if ({a_ready, b_ready} !== 2'b10) begin
      errors++;
      $display("FAIL single_ready: a_ready=%b b_ready=%b required 1 0", a_ready, b_ready);
    end
    tick();
    a_valid = 1'b0;
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, last_grant_b} !== {1'b1, 2'd2, 8'h5A, 1'b0}) begin
      errors++;
      $display("FAIL single_write: we=%b waddr=%0d wdata=%h lgb=%b required 1 2 5a 0",
               rf_we, rf_waddr, rf_wdata, last_grant_b);
    end
    tick();
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b0, 2'd2, 8'h5A}) begin
      errors++;
      $display("FAIL single_idle: we=%b waddr=%0d wdata=%h required 0 2 5a", rf_we, rf_waddr, rf_wdata);
    end
    $display("single_write: A addr 2 data 5a");
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_addr [4];
    logic [7:0] exp_data [4];
    exp_addr = '{2'd1, 2'd3, 2'd1, 2'd3};
    exp_data = '{8'h10, 8'h30, 8'h10, 8'h30};
    apply_reset();
    a_valid = 1'b1; a_addr = 2'd1; a_data = 8'h10;
    b_valid = 1'b1; b_addr = 2'd3; b_data = 8'h30;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({a_ready, b_ready} !== ((i % 2 == 0) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL rr_ready[%0d]: a_ready=%b b_ready=%b required %s", i, a_ready, b_ready,
                 (i % 2 == 0) ? "A" : "B");
      end
      tick();
      checks++;
      if ({rf_we, rf_waddr, rf_wdata, last_grant_b} !== {1'b1, exp_addr[i], exp_data[i], i[0]}) begin
        errors++;
        $display("FAIL rr_write[%0d]: we=%b waddr=%0d wdata=%h lgb=%b required 1 %0d %h %b",
                 i, rf_we, rf_waddr, rf_wdata, last_grant_b, exp_addr[i], exp_data[i], i[0]);
      end
      $display("round_robin: grant %0d -> addr %0d", i, rf_waddr);
    end
    a_valid = 1'b0; b_valid = 1'b0;
    tick();
  endtask

  task automatic test_same_addr();
    apply_reset();
    a_valid = 1'b1; a_addr = 2'd0; a_data = 8'h11;
    b_valid = 1'b1; b_addr = 2'd0; b_data = 8'h22;
    tick();
    a_valid = 1'b0;
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 2'd0, 8'h11}) begin
      errors++;
      $display("FAIL same_first: we=%b waddr=%0d wdata=%h required 1 0 11", rf_we, rf_waddr, rf_wdata);
    end
    #1;
    checks++;
    if (b_ready !== 1'b1) begin
      errors++;
      $display("FAIL same_b_ready: b_ready=%b required 1", b_ready);
    end
    tick();
    b_valid = 1'b0;
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, last_grant_b} !== {1'b1, 2'd0, 8'h22, 1'b1}) begin
      errors++;
      $display("FAIL same_second: we=%b waddr=%0d wdata=%h lgb=%b required 1 0 22 1",
               rf_we, rf_waddr, rf_wdata, last_grant_b);
    end
    tick();
    checks++;
    if ({rf_we, rf_wdata} !== {1'b0, 8'h22}) begin
      errors++;
      $display("FAIL same_final: we=%b wdata=%h required 0 22", rf_we, rf_wdata);
    end
    $display("same_addr: A then B to addr 0, final 22");
  endtask

  task automatic test_clear();
    apply_reset();
    a_valid = 1'b1; a_addr = 2'd2; a_data = 8'h77;
    clr_req = 1'b1;
    #1;
    checks++;
    if (a_ready !== 1'b0) begin
      errors++;
      $display("FAIL clear_block_ready: a_ready=%b required 0", a_ready);
    end
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({rf_we, rf_waddr, rf_wdata, clr_busy, clr_done, a_ready} !==
          {1'b1, 2'(i), 8'h00, 1'b1, (i == 3), 1'b0}) begin
        errors++;
        $display("FAIL clear_write[%0d]: we=%b waddr=%0d wdata=%h busy=%b done=%b a_ready=%b required 1 %0d 00 1 %b 0",
                 i, rf_we, rf_waddr, rf_wdata, clr_busy, clr_done, a_ready, i, (i == 3));
      end
      $display("clear: write %0d addr %0d done=%b", i, rf_waddr, clr_done);
      tick();
    end
    checks++;
    if ({rf_we, clr_busy, clr_done, a_ready} !== 4'b0001) begin
      errors++;
      $display("FAIL clear_end: we=%b busy=%b done=%b a_ready=%b required 0 0 0 1",
               rf_we, clr_busy, clr_done, a_ready);
    end
    tick();
    a_valid = 1'b0;
    checks++;
    if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 2'd2, 8'h77}) begin
      errors++;
      $display("FAIL clear_after_write: we=%b waddr=%0d wdata=%h required 1 2 77", rf_we, rf_waddr, rf_wdata);
    end
    tick();
  endtask

  task automatic test_reset_mid_clear();
    logic saw_done;
    saw_done = 1'b0;
    apply_reset();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    tick();
    checks++;
    if ({rf_we, rf_waddr, clr_busy} !== {1'b1, 2'd1, 1'b1}) begin
      errors++;
      $display("FAIL midclr_second: we=%b waddr=%0d busy=%b required 1 1 1", rf_we, rf_waddr, clr_busy);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({rf_we, rf_waddr, rf_wdata, clr_busy, clr_done} !== 13'd0) begin
      errors++;
      $display("FAIL midclr_async: we=%b waddr=%0d wdata=%h busy=%b done=%b required all 0",
               rf_we, rf_waddr, rf_wdata, clr_busy, clr_done);
    end
    tick();
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (rf_we !== 1'b0 || clr_done !== 1'b0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("FAIL midclr_quiet: write or clr_done seen after release, required none");
    end
    $display("reset_mid_clear: aborted after addr 1");
  endtask

  task automatic test_hazard();
    apply_reset();
    a_valid = 1'b1; a_addr = 2'd1; a_data = 8'h3C;
    tick();
    a_valid = 1'b0;
    rd_addr1 = 2'd1; rd_addr2 = 2'd0;
    #1;
    checks++;
    if (raw_hazard !== 1'b1) begin
      errors++;
      $display("FAIL hazard_rd1: raw_hazard=%b required 1", raw_hazard);
    end
    rd_addr1 = 2'd0;
    #1;
    checks++;
    if (raw_hazard !== 1'b0) begin
      errors++;
      $display("FAIL hazard_none: raw_hazard=%b required 0", raw_hazard);
    end
    rd_addr2 = 2'd1;
    #1;
    checks++;
    if (raw_hazard !== 1'b1) begin
      errors++;
      $display("FAIL hazard_rd2: raw_hazard=%b required 1", raw_hazard);
    end
    tick();
    rd_addr1 = 2'd1;
    #1;
    checks++;
    if (raw_hazard !== 1'b0) begin
      errors++;
      $display("FAIL hazard_no_we: raw_hazard=%b required 0", raw_hazard);
    end
    $display("hazard: rd1/rd2 compare against addr 1");
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_same_addr();
    test_clear();
    test_reset_mid_clear();
    test_hazard();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_write_ctrl.md
Name: regfile_write_ctrl

Overview:
- Sequences and arbitrates the single write port of the 4 x 8-bit register file.
- Two requesters share that port through valid/ready handshakes: port A is core write-back, port B is the debug/loader port.
- A clear sequencer zeroes every register over consecutive cycles.
- A read-after-write hazard flag tells the core when a read would return stale data.
- Sits between the core write-back/debug logic and the register file's reg_write, write_register and write_data inputs.

Parameters:
- DATA_W, 8, width of register data.
- ADDR_W, 2, width of register index.
- NUM_REGS, 4, number of registers; must equal 2**ADDR_W.
- CLR_VALUE, 0, value written to each register by the clear sequence.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset (0 = in reset).
- a_valid  in  1  core write-back request.
- a_addr  in  ADDR_W  core target register.
- a_data  in  DATA_W  core write data.
- a_ready  out  1  core request accepted this cycle.
- b_valid  in  1  debug/loader write request.
- b_addr  in  ADDR_W  debug target register.
- b_data  in  DATA_W  debug write data.
- b_ready  out  1  debug request accepted this cycle.
- clr_req  in  1  start clear sequence; level-sampled.
- clr_busy  out  1  clear sequence in progress.
- clr_done  out  1  one-cycle pulse on the final clear write.
- rd_addr1  in  ADDR_W  register file read index 1, used for hazard compare.
- rd_addr2  in  ADDR_W  register file read index 2.
- rf_we  out  1  to register file reg_write.
- rf_waddr  out  ADDR_W  to register file write_register.
- rf_wdata  out  DATA_W  to register file write_data.
- raw_hazard  out  1  pending write targets a register being read.
- last_grant_b  out  1  last accepted request came from port B.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=ARB, rr pointer=A, clear counter=0.
  - rf_we=0, rf_waddr=0, rf_wdata=0.
  - clr_busy=0, clr_done=0, last_grant_b=0.
- While reset=0, a_ready=b_ready=0 and raw_hazard=0.
- States:
  - ARB: arbitrate requesters.
  - CLEAR: counter-driven writes of CLR_VALUE.
- Ready rules (combinational, ARB only; both 0 in CLEAR):
  - If clr_req=1 in ARB, a_ready=b_ready=0; clear has priority.
  - Else a_ready = a_valid & (!b_valid | ptr==A).
  - Else b_ready = b_valid & (!a_valid | ptr==B).
  - At most one ready is high per cycle. A ready never rises without its own valid.
- Transfer = valid & ready at a rising edge. On transfer:
  - Next cycle rf_we=1, rf_waddr=addr and rf_wdata=data of the winner (latency 1).
  - ptr flips to the other port; last_grant_b updates.
- No transfer in ARB: next cycle rf_we=0; rf_waddr and rf_wdata hold their values.
- Back-to-back transfers are allowed, giving one write per cycle.
- Round-robin rule: with both valid continuously, grants alternate A,B,A,B... A lone requester is granted every cycle and ptr still flips.
- Both requesters targeting the same address in the same cycle: only the winner writes. The loser writes on a later grant, so the final value is the later grantee's data.
- Requester obligations: a requester holds valid, addr and data until ready. Dropping valid before ready is legal and no write occurs.
- Clear sequence, with clr_req sampled high in ARB at edge T:
  - Cycles T+1..T+NUM_REGS: rf_we=1, rf_waddr=0,1,..,NUM_REGS-1, rf_wdata=CLR_VALUE.
  - clr_busy=1 in those same cycles.
  - clr_done=1 only in cycle T+NUM_REGS.
  - state=ARB from T+NUM_REGS+1; the earliest new write lands at T+NUM_REGS+2.
  - clr_req during CLEAR is ignored. clr_req still high on return to ARB starts a new clear.
- Reset mid-clear: immediate return to the reset values. No clr_done is issued and the remaining registers are not written by this block.
- Hazard, combinational: raw_hazard = rf_we & (rf_waddr==rd_addr1 | rf_waddr==rd_addr2). This includes clear writes.
- All address arithmetic is ADDR_W bits. The clear counter terminates at NUM_REGS-1 and does not wrap.

Decomposition:
- Package regfile_ctrl_pkg holds:
  - DATA_W and ADDR_W defaults.
  - State encoding ARB=0, CLEAR=1.
  - Requester IDs REQ_A=0, REQ_B=1.
- Sub-module rr_arb2: a 2-way round-robin arbiter.
  - Inputs: clk, reset, req[1:0], en.
  - Outputs: gnt[1:0], one-hot or zero.
  - The pointer updates on grant & en.
- regfile_write_ctrl instantiates rr_arb2 with en = (state==ARB) & !clr_req.

Test Plan:
- Reset release, then a_valid=1, a_addr=2, a_data=8'h5A for one cycle: a_ready=1 that cycle; next cycle rf_we=1, rf_waddr=2, rf_wdata=8'h5A; the cycle after rf_we=0.
- a_valid and b_valid both held high for 4 cycles with addrs 1 and 3: grants A,B,A,B; rf_waddr sequence 1,3,1,3; last_grant_b toggles 0,1,0,1.
- Both request addr 0 (A=8'h11, B=8'h22) with ptr=A: A is written first, then B; final rf_wdata for addr 0 is 8'h22.
- clr_req pulse in ARB while a_valid=1: a_ready=0; 4 cycles of rf_we=1 with addrs 0..3 and data 8'h00; clr_done high only on addr 3; a_ready rises in the following cycle.
- reset=0 asserted during the 2nd clear write: outputs go to reset values immediately; clr_done never pulses; after release, rf_we=0 until a new request.
- rf_we=1 with rf_waddr=1 while rd_addr1=1 gives raw_hazard=1; rd_addr1=rd_addr2=0 gives raw_hazard=0; rf_we=0 with matching addrs gives raw_hazard=0.
